// File: rtl/pi1q_arb_if.sv
// ---------------------------------------------------------------------------
// pi1q_arb_if -- bus bundle for the pi1q_arb arbiter.
//
// Carries every master-side and slave-side bus signal of pi1q_arb as flat
// vectors. Master i occupies slice i of each *_flat vector.
//
// Modports:
//   slave  : the arbiter's view. It is the slave of the master group, so it
//            takes master requests in, drives master ready/read data out,
//            drives the downstream slave command and takes slave data/ready.
//   master : the environment's view (the masters plus the downstream slave
//            device). Every direction is the mirror of the slave modport.
//
// Signals:
//   m_op_i_flat    2*MASTERCOUNT          per-master op (00 NOOP,01 WR,10 RD,11 RW)
//   m_addr_i_flat  ADDRBITSZ*MASTERCOUNT  per-master word address
//   m_data_i_flat  ARCHBITSZ*MASTERCOUNT  per-master write data
//   m_sel_i_flat   SELBITSZ*MASTERCOUNT   per-master byte select
//   m_data_o_flat  ARCHBITSZ*MASTERCOUNT  per-master registered read data
//   m_rdy_o_flat   MASTERCOUNT            per-master ready
//   s_op_o         2                      slave op (NOOP when queue empty)
//   s_addr_o / s_data_o / s_sel_o         command queue head fields
//   s_data_i       ARCHBITSZ              slave read data
//   s_rdy_i        1                      slave ready
// ---------------------------------------------------------------------------
interface pi1q_arb_if #(
    parameter int MASTERCOUNT = 2,
    parameter int ARCHBITSZ   = 16
);
    localparam int SELBITSZ  = ARCHBITSZ / 8;
    localparam int ADDRBITSZ = ARCHBITSZ - $clog2(SELBITSZ);

    logic [2*MASTERCOUNT-1:0]         m_op_i_flat;
    logic [ADDRBITSZ*MASTERCOUNT-1:0] m_addr_i_flat;
    logic [ARCHBITSZ*MASTERCOUNT-1:0] m_data_i_flat;
    logic [SELBITSZ*MASTERCOUNT-1:0]  m_sel_i_flat;
    logic [ARCHBITSZ*MASTERCOUNT-1:0] m_data_o_flat;
    logic [MASTERCOUNT-1:0]           m_rdy_o_flat;

    logic [1:0]                       s_op_o;
    logic [ADDRBITSZ-1:0]             s_addr_o;
    logic [ARCHBITSZ-1:0]             s_data_o;
    logic [SELBITSZ-1:0]              s_sel_o;
    logic [ARCHBITSZ-1:0]             s_data_i;
    logic                             s_rdy_i;

    modport slave (
        input  m_op_i_flat, m_addr_i_flat, m_data_i_flat, m_sel_i_flat,
        output m_data_o_flat, m_rdy_o_flat,
        output s_op_o, s_addr_o, s_data_o, s_sel_o,
        input  s_data_i, s_rdy_i
    );

    modport master (
        output m_op_i_flat, m_addr_i_flat, m_data_i_flat, m_sel_i_flat,
        input  m_data_o_flat, m_rdy_o_flat,
        input  s_op_o, s_addr_o, s_data_o, s_sel_o,
        output s_data_i, s_rdy_i
    );
endinterface

// File: rtl/pi1q_arb.sv
// ---------------------------------------------------------------------------
// pi1q_arb -- multi-master arbiter with a DEPTH-entry command queue in front
// of a single slave. Writes are posted; a read blocks only the master that
// issued it until its data has been captured into that master's m_data_o.
//
// Ports:
//   clk_i  : clock, all state updates on the rising edge
//   rst_i  : synchronous active-high reset
//   bus    : pi1q_arb_if.slave, all master-side and slave-side bus signals
//
// Build option:
//   PI1Q_ARB_FIXEDPRIO_EN  defined   -> lowest-index requesting master wins
//                          undefined -> round-robin starting at rr_q
// ---------------------------------------------------------------------------
module pi1q_arb #(
    parameter int MASTERCOUNT = 2,
    parameter int ARCHBITSZ   = 16,
    parameter int DEPTH       = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    pi1q_arb_if.slave bus
);
    localparam int SELBITSZ  = ARCHBITSZ / 8;
    localparam int ADDRBITSZ = ARCHBITSZ - $clog2(SELBITSZ);
    localparam int PTRW      = $clog2(DEPTH);
    localparam int CNTW      = PTRW + 1;
    localparam int MIDW      = (MASTERCOUNT > 1) ? $clog2(MASTERCOUNT) : 1;

    localparam logic [1:0] OP_NOOP = 2'b00;

    // Unpacked per-master views of the flat input vectors
    logic [1:0]           m_op   [MASTERCOUNT];
    logic [ADDRBITSZ-1:0] m_addr [MASTERCOUNT];
    logic [ARCHBITSZ-1:0] m_data [MASTERCOUNT];
    logic [SELBITSZ-1:0]  m_sel  [MASTERCOUNT];
    logic [MASTERCOUNT-1:0] m_req;
    logic [MASTERCOUNT-1:0] m_rdy;

    // Command queue storage
    logic [1:0]           fifo_op_q   [DEPTH];
    logic [ADDRBITSZ-1:0] fifo_addr_q [DEPTH];
    logic [ARCHBITSZ-1:0] fifo_data_q [DEPTH];
    logic [SELBITSZ-1:0]  fifo_sel_q  [DEPTH];
    logic [MIDW-1:0]      fifo_mid_q  [DEPTH];

    logic [PTRW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]        count_q, count_d;
    logic [MASTERCOUNT-1:0] pending_q, pending_d;
    logic                   lastrd_q, lastrd_d;
    logic [MIDW-1:0]        lastmid_q, lastmid_d;
    logic [ARCHBITSZ-1:0]   m_data_q [MASTERCOUNT];

    logic [MIDW-1:0] grant;
    logic            grant_vld;
    logic            full;
    logic            push;
    logic            pop;

    assign full = (count_q == CNTW'(DEPTH));

    generate
        for (genvar gi = 0; gi < MASTERCOUNT; gi++) begin : g_master
            assign m_op[gi]   = bus.m_op_i_flat[2*gi +: 2];
            assign m_addr[gi] = bus.m_addr_i_flat[ADDRBITSZ*gi +: ADDRBITSZ];
            assign m_data[gi] = bus.m_data_i_flat[ARCHBITSZ*gi +: ARCHBITSZ];
            assign m_sel[gi]  = bus.m_sel_i_flat[SELBITSZ*gi +: SELBITSZ];

            // A master with an outstanding read is not allowed to request
            assign m_req[gi] = (m_op[gi] != OP_NOOP) && !pending_q[gi];

            // Idle masters see ready so they can collect returned read data
            assign m_rdy[gi] = !rst_i && !pending_q[gi] &&
                               (((grant == MIDW'(gi)) && !full) || (m_op[gi] == OP_NOOP));

            assign bus.m_rdy_o_flat[gi]                        = m_rdy[gi];
            assign bus.m_data_o_flat[ARCHBITSZ*gi +: ARCHBITSZ] = m_data_q[gi];
        end
    endgenerate

`ifdef PI1Q_ARB_FIXEDPRIO_EN
    // Descending scan so the lowest-index requester is the last to win
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int k = MASTERCOUNT - 1; k >= 0; k--) begin
            if (m_req[MIDW'(k)]) begin
                grant     = MIDW'(k);
                grant_vld = 1'b1;
            end
        end
    end
`else
    logic [MIDW-1:0] rr_q, rr_d;

    // Scan starting at rr_q, wrapping at MASTERCOUNT; first requester wins
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_vld = 1'b0;
        for (int k = 0; k < MASTERCOUNT; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= MASTERCOUNT) begin
                idx = idx - MASTERCOUNT;
            end
            if (!grant_vld && m_req[MIDW'(idx)]) begin
                grant     = MIDW'(idx);
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (push) begin
            if (grant == MIDW'(MASTERCOUNT - 1)) begin
                rr_d = '0;
            end else begin
                rr_d = grant + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    // Equivalent to m_rdy[grant] with a non-NOOP granted op. A full queue
    // blocks the push even if the head pops on the same edge.
    assign push = grant_vld && !full && !rst_i;
    assign pop  = bus.s_rdy_i && (count_q != '0);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        pending_d = pending_q;
        lastrd_d  = lastrd_q;
        lastmid_d = lastmid_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // The read popped on the previous s_rdy_i edge returns its data on
        // the next s_rdy_i edge; a stalled slave freezes this pipeline stage.
        if (bus.s_rdy_i) begin
            if (lastrd_q) begin
                pending_d[lastmid_q] = 1'b0;
            end
            lastrd_d  = pop && fifo_op_q[rd_ptr_q][1];
            lastmid_d = fifo_mid_q[rd_ptr_q];
        end

        // A pending master cannot be granted, so this never collides with
        // the clear above for the same master.
        if (push && m_op[grant][1]) begin
            pending_d[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= '0;
            lastrd_q  <= 1'b0;
            lastmid_q <= '0;
            for (int i = 0; i < MASTERCOUNT; i++) begin
                m_data_q[i] <= '0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            lastrd_q  <= lastrd_d;
            lastmid_q <= lastmid_d;
            if (bus.s_rdy_i && lastrd_q) begin
                m_data_q[lastmid_q] <= bus.s_data_i;
            end
        end
    end

    // Queue storage has no reset; count_q alone decides validity
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_op_q[wr_ptr_q]   <= m_op[grant];
            fifo_addr_q[wr_ptr_q] <= m_addr[grant];
            fifo_data_q[wr_ptr_q] <= m_data[grant];
            fifo_sel_q[wr_ptr_q]  <= m_sel[grant];
            fifo_mid_q[wr_ptr_q]  <= grant;
        end
    end

    assign bus.s_op_o   = (count_q == '0) ? OP_NOOP : fifo_op_q[rd_ptr_q];
    assign bus.s_addr_o = fifo_addr_q[rd_ptr_q];
    assign bus.s_data_o = fifo_data_q[rd_ptr_q];
    assign bus.s_sel_o  = fifo_sel_q[rd_ptr_q];

endmodule
